mem_port_arbiter: RTL and testbench

- Shares one single-port, word-addressed program/data memory between the instruction-fetch requester and the load/store requester.
- Provides a valid/grant handshake per requester and arbitrates each cycle.
- Maps byte addresses in the 0x0040_0000 text segment onto word indices and flags out-of-range or misaligned accesses.
- Sits between the core's fetch/LSU stages and the memory array; the memory has a 1-cycle synchronous read.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_mem_addr_map.sv | 27 ++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - owner encoding, text-segment base and address-map helpers
package mem_port_arbiter_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_IF   = 2'd1;
    localparam owner_t OWN_D    = 2'd2;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

    // Modular subtraction: addresses below base wrap and are caught by addr_err.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return {2'b00, off[31:2]};
    endfunction

    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr < base) || (word_index(addr, base) >= depth);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mem_addr_map.sv
// rtl/mem_port_arbiter_mem_addr_map.sv - combinational byte-address to word-index map with error flag
module mem_addr_map
    import mem_port_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = TEXT_BASE[ADDR_WIDTH-1:0],
    localparam int                   IW         = $clog2(DEPTH)
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [IW-1:0]         word_o,
    output logic                  err_o
);

    logic [31:0] addr32;
    logic [31:0] base32;
    logic [31:0] word32;

    always_comb begin
        addr32 = 32'(addr_i);
        base32 = 32'(BASE_ADDR);
        word32 = word_index(addr32, base32);
        word_o = word32[IW-1:0];
        err_o  = addr_err(addr32, base32, DEPTH);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/LSU arbiter in front of a single-port synchronous-read memory
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0040_0000,
    parameter int                    STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDR_WIDTH-1:0]    if_addr,
    output logic                     if_gnt,
    output logic                     if_rvalid,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    output logic                     if_err,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDR_WIDTH-1:0]    d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    output logic                     d_gnt,
    output logic                     d_rvalid,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     d_err,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int IW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [IW-1:0] if_word, d_word;
    logic          if_aerr, d_aerr;
    logic          if_win, d_win, gnt_err;

    owner_t        owner_q, owner_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [SW-1:0] starve_q, starve_d;

    mem_addr_map #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_if_map (
        .addr_i (if_addr),
        .word_o (if_word),
        .err_o  (if_aerr)
    );

    mem_addr_map #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_d_map (
        .addr_i (d_addr),
        .word_o (d_word),
        .err_o  (d_aerr)
    );

    // Loads/stores normally win; a fetch that has lost STARVE_MAX cycles in a row takes the port.
    always_comb begin
        if_win    = if_req && (!d_req || starve_q == SW'(STARVE_MAX));
        d_win     = d_req && !if_win;
        if_gnt    = if_win && !rst;
        d_gnt     = d_win && !rst;
        gnt_err   = (if_gnt && if_aerr) || (d_gnt && d_aerr);
        mem_en    = (if_gnt || d_gnt) && !gnt_err;
        mem_we    = d_gnt && d_we && !d_aerr;
        mem_addr  = if_gnt ? if_word : (d_gnt ? d_word : '0);
        mem_wdata = rst ? '0 : d_wdata;
    end

    always_comb begin
        owner_d = if_gnt ? OWN_IF : (d_gnt ? OWN_D : OWN_NONE);
        err_d   = gnt_err;
        we_d    = d_gnt && d_we;
        if (if_req && !if_gnt) begin
            starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
        end else begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            err_q    <= err_d;
            we_q     <= we_d;
            starve_q <= starve_d;
        end
    end

    // Response stage: only the owning side sees rvalid; stores and errors carry zero data.
    always_comb begin
        if_rvalid = (owner_q == OWN_IF);
        if_err    = if_rvalid && err_q;
        if_rdata  = (if_rvalid && !err_q) ? mem_rdata : '0;
        d_rvalid  = (owner_q == OWN_D);
        d_err     = d_rvalid && err_q;
        d_rdata   = (d_rvalid && !err_q && !we_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [9:0]  mem_addr;
    logic        mem_en, mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:1023];

    int    n_vec = 0;
    int    n_err = 0;
    resp_t if_q[$];
    resp_t d_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected response whenever a side presents rvalid.
    always @(negedge clk) begin
        resp_t e;
        if (if_rvalid === 1'b1) begin
            if (if_q.size() == 0) begin
                chk("if_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = if_q.pop_front();
                chk("if_rdata", if_rdata, e.data);
                chk("if_err", {31'd0, if_err}, {31'd0, e.err});
            end
        end
        if (d_rvalid === 1'b1) begin
            if (d_q.size() == 0) begin
                chk("d_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = d_q.pop_front();
                chk("d_rdata", d_rdata, e.data);
                chk("d_err", {31'd0, d_err}, {31'd0, e.err});
            end
        end
    end

    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                        input logic eig, input logic edg, input logic emen,
                        input logic [31:0] edata, input logic eerr);
        resp_t r;
        if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        @(negedge clk);
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, eig});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
        chk("mem_en", {31'd0, mem_en}, {31'd0, emen});
        #1;
        r.data = edata;
        r.err  = eerr;
        if (eig) if_q.push_back(r);
        if (edg) d_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        logic [113:0] outs;
        outs = {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
                mem_addr, mem_en, mem_we, mem_wdata};
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL %s: outputs %h expected all zero", name, outs);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0]    = 32'h0000_0013;
        mem[1]    = 32'h0010_0093;
        mem[2]    = 32'h00A0_0093;
        mem[3]    = 32'h0030_8193;
        mem[1023] = 32'hCAFE_F00D;

        // Requests asserted during reset must not leak through.
        if_req = 1'b1; if_addr = 32'h0040_0000;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0040_0000; d_wdata = 32'hFFFF_FFFF;
        #2;
        chk_all_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        rst = 1'b0;

        // fetch only
        step(1, 32'h0040_0008, 0, 0, 0, 0, 1, 0, 1, 32'h00A0_0093, 0);
        // store then load same address
        step(0, 0, 1, 1, 32'h0040_0010, 32'hDEAD_BEEF, 0, 1, 1, 32'h0, 0);
        step(0, 0, 1, 0, 32'h0040_0010, 0, 0, 1, 1, 32'hDEAD_BEEF, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // contention: d wins four cycles, then starved fetch wins once
        for (int c = 0; c < 6; c++) begin
            if (c == 4) step(1, 32'h0040_0000, 1, 0, 32'h0040_0010, 0, 1, 0, 1, 32'h0000_0013, 0);
            else        step(1, 32'h0040_0000, 1, 0, 32'h0040_0010, 0, 0, 1, 1, 32'hDEAD_BEEF, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // error cases and last valid word
        step(0, 0, 1, 0, 32'h0040_0002, 0, 0, 1, 0, 32'h0, 1);
        step(0, 0, 1, 1, 32'h0040_0006, 32'h1234_5678, 0, 1, 0, 32'h0, 1);
        step(1, 32'h003F_FFFC, 0, 0, 0, 0, 1, 0, 0, 32'h0, 1);
        step(1, 32'h0040_1000, 0, 0, 0, 0, 1, 0, 0, 32'h0, 1);
        step(1, 32'h0040_0FFC, 0, 0, 0, 0, 1, 0, 1, 32'hCAFE_F00D, 0);
        chk("mem_word1", mem[1], 32'h0010_0093);

        // back-to-back fetches
        step(1, 32'h0040_0000, 0, 0, 0, 0, 1, 0, 1, 32'h0000_0013, 0);
        step(1, 32'h0040_0004, 0, 0, 0, 0, 1, 0, 1, 32'h0010_0093, 0);
        step(1, 32'h0040_0008, 0, 0, 0, 0, 1, 0, 1, 32'h00A0_0093, 0);
        step(1, 32'h0040_000C, 0, 0, 0, 0, 1, 0, 1, 32'h0030_8193, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset between grant and response
        if_req = 1'b1; if_addr = 32'h0040_0000;
        @(negedge clk);
        chk("rst_pre_gnt", {31'd0, if_gnt}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async_outputs");
        @(posedge clk);
        #1;
        chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        if_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 32'h0040_0004, 0, 0, 0, 0, 1, 0, 1, 32'h0010_0093, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        chk("if_q_drained", if_q.size(), 32'd0);
        chk("d_q_drained", d_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
